rob_commit_unit: RTL
====================

# rob_commit_unit

Multi-lane in-order commit stage between the reorder buffer head and the register file / L1 data cache. Each cycle it inspects the oldest `commit_width` ROB entries and retires the longest ready prefix. It writes register results, clears busy tags and pulses the ROB dequeue count. Stores are sequenced through a registered dmem handshake FSM, and a mispredicted branch raises a one-cycle flush. It is the parametrised successor of the single-lane write-results controller and adds multi-lane retire, store sequencing, flush and a retire counter.

## Interface

Parameters:
- `data_width`, 16, register value and address width.
- `tag_width`, 3, ROB tag width.
- `commit_width`, 2, number of head entries examined per cycle (1..4).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `head_valid`  in  commit_width  lane i holds a live ROB entry (lane 0 = oldest).
- `head_ready`  in  commit_width  lane i's result is complete.
- `head_opcode`  in  4*commit_width  `lc3b_opcode` per lane.
- `head_dest`  in  3*commit_width  `lc3b_reg` per lane.
- `head_value`  in  data_width*commit_width  result value, or store data.
- `head_addr`  in  data_width*commit_width  store address (meaningful only for ST/STB/STI).
- `head_tag`  in  tag_width*commit_width  ROB tag per lane.
- `head_mispredict`  in  commit_width  lane i is a branch resolved as mispredicted.
- `dmem_resp`  in  1  L1 cache completes the outstanding write.
- `rf_we`  out  commit_width  regfile value write enable per lane.
- `rf_dest`  out  3*commit_width  destination per lane (pass-through of `head_dest`).
- `rf_value`  out  data_width*commit_width  value per lane (pass-through of `head_value`).
- `rf_clr_tag`  out  commit_width  clear busy if the regfile tag equals `rf_tag` for that lane.
- `rf_tag`  out  tag_width*commit_width  tag per lane.
- `dmem_write`  out  1  registered store request.
- `dmem_address`  out  data_width  registered store address.
- `dmem_wdata`  out  data_width  registered store data.
- `dmem_read`  out  1  tied to 0; loads are executed elsewhere.
- `RE_count`  out  $clog2(commit_width+1)  number of entries dequeued this cycle.
- `flush_out`  out  1  one-cycle pipeline flush.
- `retired_count`  out  32  total retired instructions.

## Operation

Classification:
- Store lane: opcode ST, STB or STI.
- Register-writing lane: opcode ADD, AND, NOT, LDR, LDB, LDI, LEA, SHF or TRAP.
- Other opcodes (BR, JMP) write nothing.

Commit eligibility, combinational, computed only in state IDLE. Lane i commits iff:
- lanes 0..i-1 all commit; and
- lane i is valid and ready; and
- lane i is not a store; and
- no lower lane is mispredicted.

`RE_count` equals the number of committing lanes. `rf_we[i]` and `rf_clr_tag[i]` are set only for committing register-writing lanes.

Mispredict:
- A committing lane with `head_mispredict` still writes its register if applicable.
- `flush_out` is registered and asserted for exactly the cycle after that commit.
- Younger lanes never commit in the same cycle.

Store FSM (states IDLE, ST_REQ):
- IDLE: if lane 0 is a valid, ready store and no flush is pending:
  - latch `head_addr[0]` and `head_value[0]` into `dmem_address` / `dmem_wdata`;
  - set `dmem_write`=1 next cycle and go to ST_REQ;
  - `RE_count`=0 this cycle.
- A store in lane k>0 blocks lanes k and above. It waits until it reaches lane 0.
- ST_REQ: hold `dmem_write`=1 and stable address/data. No lanes commit.
  - On `dmem_resp`=1: `RE_count`=1 and `dmem_write`=0 next cycle, then IDLE.
  - The store's `rf_clr_tag[0]` stays 0.

Other rules:
- `retired_count` increments by `RE_count` each cycle and wraps modulo 2^32.
- While `flush_out`=1, `RE_count`=0 and no lane commits; the ROB is being cleared that cycle.

Reset (`reset_n`=0 at a rising edge):
- State goes to IDLE.
- `dmem_write`, `flush_out`, `dmem_address`, `dmem_wdata` and `retired_count` go to 0.
- Combinational outputs are forced to 0 while `reset_n`=0.
- Reset during ST_REQ abandons the store; the cache must tolerate the dropped request.

## Timing

- Register commit: zero-cycle; `rf_we` and `RE_count` are valid in the same cycle as `head_*`.
- Store:
  - request appears 1 cycle after eligibility;
  - `RE_count`=1 in the cycle `dmem_resp`=1 is sampled in ST_REQ;
  - minimum total of 2 cycles per store.
- `flush_out`: 1 cycle after the mispredicted commit, width exactly 1 cycle.
- `dmem_resp` in IDLE is ignored.

## Test plan

- Two-lane register retire:
  - Stimulus: `commit_width`=2; lane0 ADD R1=0x0005, lane1 AND R2=0x00F0, both valid and ready.
  - Response: `rf_we`=2'b11, `RE_count`=2, `retired_count` +2.
- Ready gap:
  - Stimulus: lane0 not ready, lane1 ready.
  - Response: `RE_count`=0 and `rf_we`=0 until lane0 is ready.
- Store handshake:
  - Stimulus: lane0 ST addr=0x3000 data=0xBEEF; `dmem_resp` held off for 3 cycles.
  - Response: `dmem_write`=1 with stable address/data for 3 cycles; `RE_count`=1 exactly on the resp cycle; `dmem_write`=0 next cycle.
- Store in lane 1:
  - Stimulus: lane0 ADD, lane1 STB.
  - Response: `RE_count`=1 (ADD only); STB is requested once it is in lane 0.
- Mispredict:
  - Stimulus: lane0 BR with `head_mispredict`, lane1 ADD ready.
  - Response: `RE_count`=1, `rf_we[1]`=0, `flush_out`=1 on the next cycle only, `RE_count`=0 during the flush.
- Reset mid-store:
  - Stimulus: assert `reset_n`=0 while in ST_REQ.
  - Response: next cycle `dmem_write`=0, `retired_count`=0, state IDLE.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - multi-lane in-order ROB commit with store sequencing and flush
module rob_commit_unit #(
    parameter int data_width   = 16,
    parameter int tag_width    = 3,
    parameter int commit_width = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [commit_width-1:0]            head_valid,
    input  logic [commit_width-1:0]            head_ready,
    input  logic [4*commit_width-1:0]          head_opcode,
    input  logic [3*commit_width-1:0]          head_dest,
    input  logic [data_width*commit_width-1:0] head_value,
    input  logic [data_width*commit_width-1:0] head_addr,
    input  logic [tag_width*commit_width-1:0]  head_tag,
    input  logic [commit_width-1:0]            head_mispredict,
    input  logic                               dmem_resp,
    output logic [commit_width-1:0]            rf_we,
    output logic [3*commit_width-1:0]          rf_dest,
    output logic [data_width*commit_width-1:0] rf_value,
    output logic [commit_width-1:0]            rf_clr_tag,
    output logic [tag_width*commit_width-1:0]  rf_tag,
    output logic                               dmem_write,
    output logic [data_width-1:0]              dmem_address,
    output logic [data_width-1:0]              dmem_wdata,
    output logic                               dmem_read,
    output logic [$clog2(commit_width+1)-1:0]  RE_count,
    output logic                               flush_out,
    output logic [31:0]                        retired_count
);

    localparam int cnt_width = $clog2(commit_width + 1);

    // LC-3b opcode encodings relevant to retirement (STR is the plain store)
    localparam logic [3:0] op_add  = 4'b0001;
    localparam logic [3:0] op_ldb  = 4'b0010;
    localparam logic [3:0] op_stb  = 4'b0011;
    localparam logic [3:0] op_and  = 4'b0101;
    localparam logic [3:0] op_ldr  = 4'b0110;
    localparam logic [3:0] op_str  = 4'b0111;
    localparam logic [3:0] op_not  = 4'b1001;
    localparam logic [3:0] op_ldi  = 4'b1010;
    localparam logic [3:0] op_sti  = 4'b1011;
    localparam logic [3:0] op_shf  = 4'b1101;
    localparam logic [3:0] op_lea  = 4'b1110;
    localparam logic [3:0] op_trap = 4'b1111;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ST_REQ = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [commit_width-1:0] lane_store;
    logic [commit_width-1:0] lane_regw;
    logic [commit_width-1:0] lane_commit;
    logic [cnt_width-1:0]    commit_cnt;
    logic                    chain_ok;
    logic                    store_start;
    logic                    flush_set;

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    function automatic logic op_is_regw(input logic [3:0] op);
        return (op == op_add) || (op == op_and) || (op == op_not) ||
               (op == op_ldr) || (op == op_ldb) || (op == op_ldi) ||
               (op == op_lea) || (op == op_shf) || (op == op_trap);
    endfunction

    // Upper-lane store addresses are never consumed: a store only issues from lane 0
    generate
        if (commit_width > 1) begin : g_unused
            logic unused_addr;
            assign unused_addr = ^head_addr[data_width*commit_width-1:data_width];
        end
    endgenerate

    assign dmem_read = 1'b0;

    // Per-lane opcode classification
    always_comb begin
        lane_store = '0;
        lane_regw  = '0;
        for (int i = 0; i < commit_width; i++) begin
            lane_store[i] = op_is_store(head_opcode[i*4 +: 4]);
            lane_regw[i]  = op_is_regw(head_opcode[i*4 +: 4]);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: start a store from lane 0, finish it on the cache response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (store_start) state_next = ST_REQ;
            ST_REQ:  if (dmem_resp)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: longest ready prefix stopping at stores and after a mispredict
    always_comb begin
        lane_commit = '0;
        commit_cnt  = '0;
        chain_ok    = 1'b1;
        store_start = 1'b0;
        flush_set   = 1'b0;
        rf_we       = '0;
        rf_clr_tag  = '0;
        rf_dest     = '0;
        rf_value    = '0;
        rf_tag      = '0;
        RE_count    = '0;
        if (reset_n) begin
            rf_dest  = head_dest;
            rf_value = head_value;
            rf_tag   = head_tag;
            case (state)
                IDLE: begin
                    // The cycle after a flush the ROB contents are being discarded
                    if (!flush_out) begin
                        for (int i = 0; i < commit_width; i++) begin
                            lane_commit[i] = chain_ok & head_valid[i] & head_ready[i] & ~lane_store[i];
                            chain_ok       = lane_commit[i] & ~head_mispredict[i];
                            commit_cnt     = commit_cnt + cnt_width'(lane_commit[i]);
                        end
                        store_start = head_valid[0] & head_ready[0] & lane_store[0];
                    end
                    RE_count = commit_cnt;
                end
                ST_REQ: begin
                    // The store dequeues on its response; it has no register tag to clear
                    if (dmem_resp) RE_count = cnt_width'(1);
                end
                default: RE_count = '0;
            endcase
            rf_we      = lane_commit & lane_regw;
            rf_clr_tag = lane_commit & lane_regw;
            flush_set  = |(lane_commit & head_mispredict);
        end
    end

    // Registered store request, flush pulse and retire counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dmem_write    <= 1'b0;
            dmem_address  <= '0;
            dmem_wdata    <= '0;
            flush_out     <= 1'b0;
            retired_count <= '0;
        end else begin
            dmem_write <= (state_next == ST_REQ);
            if (store_start) begin
                dmem_address <= head_addr[data_width-1:0];
                dmem_wdata   <= head_value[data_width-1:0];
            end
            flush_out     <= flush_set;
            retired_count <= retired_count + 32'(RE_count);
        end
    end

endmodule
